// File: rtl/gf_pkg.sv
// GF(2^8) arithmetic (poly 0x11D) and shared types for the RS decoder.
// Pure package: no state, no timing.
package gf_pkg;
   localparam int SYMB_WIDTH = 8;
   localparam int T_LEN      = 8;
   localparam int ITER_NUM   = 2*T_LEN;
   localparam int L_WIDTH    = $clog2(2*T_LEN+1);
   localparam int R_WIDTH    = $clog2(ITER_NUM);
   localparam logic [SYMB_WIDTH-1:0] GF_POLY_LO = 8'h1D;

   typedef logic [SYMB_WIDTH-1:0] symb_t;
   typedef symb_t [T_LEN:0]       poly_t;
   typedef symb_t [2*T_LEN-1:0]   synd_t;

   typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} bm_state_t;

   // Shift-and-add multiply with modular reduction on every shift.
   function automatic symb_t gf_mult(input symb_t a, input symb_t b);
      symb_t acc;
      symb_t sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < SYMB_WIDTH; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ GF_POLY_LO) : (sh << 1);
      end
      return acc;
   endfunction
endpackage

// File: rtl/rs_bm_discrepancy.sv
// BM discrepancy delta = XOR_j lambda[j]*S[r-j], terms with r-j<0 excluded.
// Purely combinational; no flow control.
module rs_bm_discrepancy
   import gf_pkg::*;
(
   input  poly_t              lambda,
   input  synd_t              syndrome,
   input  logic [R_WIDTH-1:0] r,
   output symb_t              delta
);
   symb_t term [T_LEN+1];

   for (genvar j = 0; j <= T_LEN; j++) begin : g_term
      if (j == 0) begin : g_first
         assign term[j] = gf_mult(lambda[j], syndrome[r]);
      end else begin : g_rest
         logic [R_WIDTH-1:0] idx;
         assign idx     = r - R_WIDTH'(j);
         assign term[j] = (r >= R_WIDTH'(j)) ? gf_mult(lambda[j], syndrome[idx]) : '0;
      end
   end

   always_comb begin
      delta = '0;
      for (int j = 0; j <= T_LEN; j++) delta = delta ^ term[j];
   end
endmodule

// File: rtl/rs_berlekamp_massey.sv
// Inversionless Berlekamp-Massey: syndromes in, unnormalised error locator out.
// vld pulse ITER_NUM+1 cycles after capture; rdy low while a codeword is in flight.
module rs_berlekamp_massey
   import gf_pkg::*;
(
   input  logic               aclk,
   input  logic               aresetn,
   input  synd_t              syndrome,
   input  logic               syndrome_vld,
   output logic               syndrome_rdy,
   output poly_t              error_locator,
   output logic               error_locator_vld,
   output logic [L_WIDTH-1:0] error_locator_deg,
   output logic               rs_bm_err
);
   // B only needs x^0..x^(T_LEN-1): its top coefficient would be shifted out before use.
   typedef symb_t [T_LEN-1:0] bpoly_t;
   localparam poly_t POLY_ONE = poly_t'(1);

   bm_state_t          state, state_nxt;
   logic               capture, iter_en, done;
   synd_t              s_q;
   poly_t              lambda_q, lambda_nxt, xb;
   bpoly_t             b_q;
   symb_t              gamma_q, delta;
   logic [L_WIDTH-1:0] l_q, l_nxt;
   logic [L_WIDTH:0]   l_sum;
   logic [R_WIDTH-1:0] r_q;
   logic               update;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (syndrome_vld) state_nxt = ST_ITER;
         ST_ITER: if (r_q == R_WIDTH'(ITER_NUM-1)) state_nxt = ST_DONE;
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      syndrome_rdy = (state == ST_IDLE);
      capture      = syndrome_rdy && syndrome_vld;
      iter_en      = (state == ST_ITER);
      done         = (state == ST_DONE);
   end

   rs_bm_discrepancy u_disc (
      .lambda   (lambda_q),
      .syndrome (s_q),
      .r        (r_q),
      .delta    (delta)
   );

   assign xb = {b_q, {SYMB_WIDTH{1'b0}}};

   for (genvar j = 0; j <= T_LEN; j++) begin : g_lam
      assign lambda_nxt[j] = gf_mult(gamma_q, lambda_q[j]) ^ gf_mult(delta, xb[j]);
   end

   always_comb begin
      update = (delta != '0) && ({l_q, 1'b0} <= (L_WIDTH+1)'(r_q));
      l_sum  = (L_WIDTH+1)'(r_q) + (L_WIDTH+1)'(1) - (L_WIDTH+1)'(l_q);
      l_nxt  = (l_sum > (L_WIDTH+1)'(ITER_NUM)) ? L_WIDTH'(ITER_NUM) : l_sum[L_WIDTH-1:0];
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         s_q      <= '0;
         lambda_q <= '0;
         b_q      <= '0;
         gamma_q  <= '0;
         l_q      <= '0;
         r_q      <= '0;
      end else if (capture) begin
         s_q      <= syndrome;
         lambda_q <= POLY_ONE;
         b_q      <= bpoly_t'(1);
         gamma_q  <= SYMB_WIDTH'(1);
         l_q      <= '0;
         r_q      <= '0;
      end else if (iter_en) begin
         lambda_q <= lambda_nxt;
         r_q      <= r_q + R_WIDTH'(1);
         if (update) begin
            b_q     <= lambda_q[T_LEN-1:0];
            gamma_q <= delta;
            l_q     <= l_nxt;
         end else begin
            b_q     <= xb[T_LEN-1:0];
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         error_locator     <= '0;
         error_locator_vld <= 1'b0;
         error_locator_deg <= '0;
         rs_bm_err         <= 1'b0;
      end else begin
         error_locator_vld <= done;
         if (done) begin
            error_locator     <= lambda_q;
            error_locator_deg <= l_q;
            rs_bm_err         <= (l_q > L_WIDTH'(T_LEN));
         end
      end
   end
endmodule

// File: tb/tb_rs_berlekamp_massey.sv
// Scoreboarded bench: errors -> syndromes -> classic Massey reference (with inverses).
module tb_rs_berlekamp_massey;
   import gf_pkg::*;

   logic               aclk = 1'b0;
   logic               aresetn = 1'b0;
   synd_t              syndrome;
   logic               syndrome_vld;
   logic               syndrome_rdy;
   poly_t              error_locator;
   logic               error_locator_vld;
   logic [L_WIDTH-1:0] error_locator_deg;
   logic               rs_bm_err;

   rs_berlekamp_massey dut (
      .aclk              (aclk),
      .aresetn           (aresetn),
      .syndrome          (syndrome),
      .syndrome_vld      (syndrome_vld),
      .syndrome_rdy      (syndrome_rdy),
      .error_locator     (error_locator),
      .error_locator_vld (error_locator_vld),
      .error_locator_deg (error_locator_deg),
      .rs_bm_err         (rs_bm_err)
   );

   always #5 aclk = ~aclk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input bit ok, input string name, input int got, input int want);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
      end
   endtask

   // GF(2^8) by log/antilog tables
   int gexp [0:509];
   int glog [0:255];

   function automatic int gmul(input int a, input int b);
      if (a == 0 || b == 0) return 0;
      return gexp[glog[a] + glog[b]];
   endfunction

   function automatic int ginv(input int a);
      return gexp[(255 - glog[a]) % 255];
   endfunction

   // error pattern, syndromes and reference result
   int n_err;
   int err_loc [0:15];
   int err_val [0:15];
   int m_s     [0:15];
   int m_c     [0:8];
   int m_l;

   // expected-result store, indexed by the scoreboard queue
   int  e_lam   [0:63][0:8];
   int  e_deg   [0:63];
   int  e_err   [0:63];
   bit  e_exact [0:63];
   bit  e_roots [0:63];
   int  e_nloc  [0:63];
   int  e_loc   [0:63][0:15];
   time e_cap   [0:63];
   int  nexp = 0;
   int  sbq [$];

   task automatic pick_errors(input int n);
      bit used [0:254];
      int loc;
      for (int i = 0; i < 255; i++) used[i] = 1'b0;
      n_err = n;
      for (int k = 0; k < n; k++) begin
         do loc = int'($urandom_range(0, 254)); while (used[loc]);
         used[loc]  = 1'b1;
         err_loc[k] = loc;
         err_val[k] = int'($urandom_range(1, 255));
      end
   endtask

   task automatic build_synd();
      for (int i = 0; i < 16; i++) begin
         m_s[i] = 0;
         for (int k = 0; k < n_err; k++)
            m_s[i] = m_s[i] ^ gmul(err_val[k], gexp[(err_loc[k] * i) % 255]);
      end
   endtask

   // Massey's algorithm with explicit inverse and shift count m, polynomials kept to x^8.
   task automatic model_run();
      int bb [0:8];
      int tmp [0:8];
      int m, b, d, coef;
      for (int i = 0; i <= 8; i++) begin m_c[i] = 0; bb[i] = 0; end
      m_c[0] = 1; bb[0] = 1; m_l = 0; m = 1; b = 1;
      for (int n = 0; n < 16; n++) begin
         d = 0;
         for (int i = 0; i <= 8; i++) if (n - i >= 0) d = d ^ gmul(m_c[i], m_s[n-i]);
         if (d == 0) begin
            m++;
         end else begin
            coef = gmul(d, ginv(b));
            for (int i = 0; i <= 8; i++) tmp[i] = m_c[i];
            for (int i = 0; i <= 8; i++) if (i - m >= 0) m_c[i] = m_c[i] ^ gmul(coef, bb[i-m]);
            if (2*m_l <= n) begin
               m_l = n + 1 - m_l;
               for (int i = 0; i <= 8; i++) bb[i] = tmp[i];
               b = d;
               m = 1;
            end else begin
               m++;
            end
         end
      end
   endtask

   task automatic send(input bit push, input bit roots, input bit exact, output time cap);
      bit ok;
      bit got;
      int id;
      build_synd();
      model_run();
      @(negedge aclk);
      for (int i = 0; i < 16; i++) syndrome[i] = symb_t'(m_s[i]);
      syndrome_vld = 1'b1;
      got = 1'b0;
      cap = 0;
      for (int t = 0; t < 100 && !got; t++) begin
         ok = syndrome_rdy;
         @(posedge aclk);
         if (ok) begin got = 1'b1; cap = $time; end
         else @(negedge aclk);
      end
      if (!got) chk(1'b0, "accept_timeout", 0, 1);
      @(negedge aclk);
      syndrome_vld = 1'b0;
      if (push && got) begin
         id = nexp++;
         for (int j = 0; j <= 8; j++) e_lam[id][j] = m_c[j];
         e_deg[id]   = m_l;
         e_err[id]   = (m_l > T_LEN) ? 1 : 0;
         e_exact[id] = exact;
         e_roots[id] = roots;
         e_nloc[id]  = n_err;
         for (int k = 0; k < n_err; k++) e_loc[id][k] = err_loc[k];
         e_cap[id]   = cap;
         sbq.push_back(id);
      end
   endtask

   // monitor: one scoreboard pop per vld pulse
   initial begin
      int  id, d0, r0, badj, v;
      bit  ok;
      forever begin
         @(negedge aclk);
         if (aresetn && error_locator_vld) begin
            if (sbq.size() == 0) begin
               chk(1'b0, "unexpected_vld", 1, 0);
            end else begin
               id = sbq.pop_front();
               chk(($time - e_cap[id]) == 175, "latency", int'($time - e_cap[id]), 175);
               chk(int'(error_locator_deg) == e_deg[id], "deg", int'(error_locator_deg), e_deg[id]);
               chk(int'(rs_bm_err) == e_err[id], "err", int'(rs_bm_err), e_err[id]);
               d0 = int'(error_locator[0]);
               r0 = e_lam[id][0];
               chk(d0 != 0, "lambda0_nonzero", d0, 1);
               ok = 1'b1; badj = 0;
               for (int j = 0; j <= 8; j++) begin
                  if (e_exact[id]) begin
                     if (int'(error_locator[j]) != e_lam[id][j]) begin ok = 1'b0; badj = j; end
                  end else if (gmul(int'(error_locator[j]), r0) != gmul(e_lam[id][j], d0)) begin
                     ok = 1'b0; badj = j;
                  end
               end
               chk(ok, "lambda_coeff", int'(error_locator[badj]), e_lam[id][badj]);
               if (e_roots[id]) begin
                  ok = 1'b1; v = 0;
                  for (int k = 0; k < e_nloc[id]; k++) begin
                     int acc;
                     acc = 0;
                     for (int j = 0; j <= 8; j++)
                        acc = acc ^ gmul(int'(error_locator[j]),
                                         gexp[(((255 - e_loc[id][k]) % 255) * j) % 255]);
                     if (acc != 0) begin ok = 1'b0; v = acc; end
                  end
                  chk(ok, "roots", v, 0);
               end
            end
         end
      end
   end

   initial begin
      int  x, tries;
      bit  found;
      time cap_a, cap_b, cap_x;
      x = 1;
      for (int i = 0; i < 255; i++) begin
         gexp[i] = x; gexp[i+255] = x; glog[x] = i;
         x = x << 1;
         if ((x & 256) != 0) x = x ^ 'h11D;
      end
      glog[0] = 0;
      syndrome     = '0;
      syndrome_vld = 1'b0;

      repeat (3) @(negedge aclk);
      chk(syndrome_rdy == 1'b1, "reset_rdy", int'(syndrome_rdy), 1);
      chk(error_locator_vld == 1'b0, "reset_vld", int'(error_locator_vld), 0);
      chk(error_locator == '0, "reset_locator", int'(error_locator[0]), 0);
      chk(error_locator_deg == '0 && rs_bm_err == 1'b0, "reset_deg_err",
          int'(error_locator_deg), 0);
      aresetn = 1'b1;

      // all-zero syndromes
      n_err = 0;
      send(1'b1, 1'b0, 1'b1, cap_x);
      // single error 0x01 at alpha^5
      n_err = 1; err_loc[0] = 5; err_val[0] = 1;
      send(1'b1, 1'b1, 1'b0, cap_x);
      // 8 errors at alpha^0..alpha^7
      n_err = 8;
      for (int k = 0; k < 8; k++) begin
         err_loc[k] = k;
         err_val[k] = int'($urandom_range(1, 255));
      end
      send(1'b1, 1'b1, 1'b0, cap_x);
      // random correctable patterns
      for (int t = 0; t < 6; t++) begin
         pick_errors(int'($urandom_range(1, 8)));
         send(1'b1, 1'b1, 1'b0, cap_x);
      end
      // 9-error pattern driving L past T_LEN
      found = 1'b0;
      for (tries = 0; tries < 300 && !found; tries++) begin
         pick_errors(9);
         build_synd();
         model_run();
         if (m_l > T_LEN) found = 1'b1;
      end
      chk(found, "find_l9_pattern", m_l, 9);
      send(1'b1, 1'b0, 1'b0, cap_x);

      // second vld while busy is held off until the first codeword is done
      pick_errors(3);
      send(1'b1, 1'b1, 1'b0, cap_a);
      repeat (2) @(negedge aclk);
      chk(syndrome_rdy == 1'b0, "busy_rdy", int'(syndrome_rdy), 0);
      pick_errors(5);
      send(1'b1, 1'b1, 1'b0, cap_b);
      chk((cap_b - cap_a) == 180, "throughput", int'(cap_b - cap_a), 180);

      // reset at r=5 aborts the codeword
      pick_errors(4);
      send(1'b0, 1'b0, 1'b0, cap_x);
      repeat (5) @(negedge aclk);
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      chk(syndrome_rdy == 1'b1, "abort_rdy", int'(syndrome_rdy), 1);
      chk(error_locator == '0, "abort_locator", int'(error_locator[1]), 0);
      chk(error_locator_deg == '0 && rs_bm_err == 1'b0, "abort_deg_err",
          int'(error_locator_deg), 0);
      repeat (25) @(negedge aclk);
      pick_errors(6);
      send(1'b1, 1'b1, 1'b0, cap_x);

      for (int t = 0; t < 100 && sbq.size() != 0; t++) @(negedge aclk);
      chk(sbq.size() == 0, "drain", sbq.size(), 0);
      repeat (2) @(negedge aclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
